rst_seq_boolean: RTL and testbench
==================================

RST_SEQ_BOOLEAN -- requirements
Module: rst_seq_boolean

Interface
REQ-001 SHALL have parameter N_LOCK, default 1: number of lock inputs (1..8).
REQ-002 SHALL have parameter N_STAGES, default 2: number of sequenced reset outputs (1..8).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth on each lock input (>=2).
REQ-004 SHALL have parameter HOLD_CYCLES, default 16: cycles of stable lock required before the first release.
REQ-005 SHALL have parameter STAGE_GAP, default 8: cycles between successive stage releases (>=1).
REQ-006 SHALL have parameter FILTER_CYCLES, default 4: consecutive unlocked cycles that constitute a lock loss (>=1).
REQ-007 SHALL have parameter CNT_W, default 8: width of the lock-loss counter.
REQ-008 SHALL have port i_clk, input, 1: the single clock; all flops are on its rising edge.
REQ-009 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-010 SHALL have port i_locked, input, N_LOCK: PLL/MMCM lock flags, asynchronous to i_clk.
REQ-011 SHALL have port i_sw_rst, input, 1: synchronous software reset request, level-sensitive.
REQ-012 SHALL have port o_rst, output, N_STAGES: active-high registered resets; bit 0 is released first.
REQ-013 SHALL have port o_ready, output, 1: high while all stages are released.
REQ-014 SHALL have port o_lock_loss_cnt, output, CNT_W: saturating count of filtered lock losses.
REQ-015 SHALL have port o_state, output, 2: FSM state, encoded WAIT_LOCK=0, HOLD=1, RELEASE=2, RUN=3.

Function
REQ-016 SHALL pass each i_locked bit through its own SYNC_STAGES flop chain; lk = AND of all synchronizer outputs.
REQ-017 SHALL, in WAIT_LOCK, hold all o_rst=1 and o_ready=0, and move to HOLD with the hold counter cleared on the first edge at which lk=1.
REQ-018 SHALL, in HOLD, increment the hold counter each cycle while lk=1, and return to WAIT_LOCK on any cycle with lk=0 (counter cleared, o_lock_loss_cnt unchanged).
REQ-019 SHALL, on the HOLD_CYCLES-th HOLD edge, clear o_rst[0] and enter RELEASE; if N_STAGES=1, it SHALL instead enter RUN with o_ready=1 on that same edge.
REQ-020 SHALL, in RELEASE, clear o_rst[k] exactly k*STAGE_GAP edges after o_rst[0] cleared; on the edge that clears o_rst[N_STAGES-1], it SHALL enter RUN and set o_ready=1.
REQ-021 SHALL, in RELEASE and RUN, count consecutive cycles with lk=0 and reset that count whenever lk=1; on reaching FILTER_CYCLES it SHALL set all o_rst=1 and o_ready=0 on that edge, increment o_lock_loss_cnt (saturating at all-ones), and enter WAIT_LOCK.
REQ-022 SHALL, in any state, treat i_sw_rst=1 sampled on an edge as follows: enter WAIT_LOCK, set all o_rst=1 and o_ready=0, and leave o_lock_loss_cnt unchanged.
REQ-023 SHALL, when i_sw_rst and filter expiry coincide, enter WAIT_LOCK and increment the counter.
REQ-024 SHALL never re-assert a released stage individually; all stages re-assert together.
REQ-025 SHALL keep o_rst monotone during release: o_rst[k] cleared implies o_rst[j] cleared for all j<k.

Reset
REQ-026 SHALL, while i_rst_n=0, immediately (asynchronously) force o_rst=all-ones, o_ready=0, o_lock_loss_cnt=0, o_state=WAIT_LOCK, and clear synchronizers and counters.
REQ-027 SHALL, after i_rst_n rises, start from WAIT_LOCK on the first i_clk edge; no output may change before that edge.

Verification (defaults)
REQ-028 Verification SHALL cover cold start: i_locked=1 sampled from edge 1 -> o_rst[0] falls at edge 19; o_rst[1] falls and o_ready rises at edge 27.
REQ-029 Verification SHALL cover glitch rejection: in RUN, lk low for 3 cycles -> no output change, counter=0; lk low for 4 cycles -> o_rst=2'b11 on the 4th edge, counter=1, state=0.
REQ-030 Verification SHALL cover HOLD abort: lk drops at hold count 10 -> WAIT_LOCK, counter unchanged; after relock, a full 16-cycle HOLD is required again.
REQ-031 Verification SHALL cover software reset: 1-cycle i_sw_rst in RUN with lock steady -> o_rst=2'b11 next edge, HOLD entered the following edge, o_rst[0] released 16 edges later, counter unchanged.
REQ-032 Verification SHALL cover async reset mid-RELEASE: i_rst_n low between edges -> outputs reach their reset values before the next edge.
REQ-033 Verification SHALL cover saturation: 256 filtered losses -> o_lock_loss_cnt=255, remaining at 255.

Source files
------------

// File: rtl/rst_seq_boolean.sv
// Lock-qualified reset sequencer: waits for stable PLL lock, then releases
// reset stages in order and re-asserts them all on filtered lock loss or software reset.
//
// state     | meaning
// WAIT_LOCK | all resets asserted, waiting for synchronized lock
// HOLD      | lock seen, counting stable cycles before first release
// RELEASE   | stages releasing one by one, STAGE_GAP apart
// RUN       | all stages released, o_ready high
module rst_seq_boolean #(
  parameter int N_LOCK        = 1,
  parameter int N_STAGES      = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int STAGE_GAP     = 8,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_LOCK-1:0]   i_locked,
  input  logic                i_sw_rst,
  output logic [N_STAGES-1:0] o_rst,
  output logic                o_ready,
  output logic [CNT_W-1:0]    o_lock_loss_cnt,
  output logic [1:0]          o_state
);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] HOLD      = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int FILT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

  logic [N_LOCK-1:0][SYNC_STAGES-1:0] sync_q;
  logic                               lk;
  logic [1:0]                         state;
  logic [HOLD_W-1:0]                  hold_cnt;
  logic [GAP_W-1:0]                   gap_cnt;
  logic [FILT_W-1:0]                  loss_cnt;
  logic [N_STAGES-1:0]                rst_shift;
  logic                               last_stage;
  logic                               lock_lost;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      for (int i = 0; i < N_LOCK; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], i_locked[i]};
      end
    end
  end

  always_comb begin
    lk = 1'b1;
    for (int i = 0; i < N_LOCK; i++) begin
      lk = lk & sync_q[i][SYNC_STAGES-1];
    end
  end

  // Shifting in zeros from bit 0 keeps the release order monotone.
  assign rst_shift  = o_rst << 1;
  assign last_stage = (rst_shift == '0);
  assign lock_lost  = ((state == RELEASE) || (state == RUN)) && !lk && (loss_cnt == FILT_LAST);
  assign o_state    = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= WAIT_LOCK;
      o_rst           <= '1;
      o_ready         <= 1'b0;
      o_lock_loss_cnt <= '0;
      hold_cnt        <= '0;
      gap_cnt         <= '0;
      loss_cnt        <= '0;
    end else begin
      // A filtered loss is counted even when a software reset lands on the same edge.
      if (lock_lost && (o_lock_loss_cnt != '1)) begin
        o_lock_loss_cnt <= o_lock_loss_cnt + 1'b1;
      end
      if (i_sw_rst || lock_lost) begin
        state    <= WAIT_LOCK;
        o_rst    <= '1;
        o_ready  <= 1'b0;
        hold_cnt <= '0;
        loss_cnt <= '0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (lk) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
          HOLD: begin
            if (!lk) begin
              state    <= WAIT_LOCK;
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
              o_rst    <= rst_shift;
              gap_cnt  <= GAP_LAST;
              loss_cnt <= '0;
              if (N_STAGES == 1) begin
                state   <= RUN;
                o_ready <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          RELEASE: begin
            loss_cnt <= lk ? '0 : loss_cnt + 1'b1;
            if (gap_cnt == '0) begin
              o_rst   <= rst_shift;
              gap_cnt <= GAP_LAST;
              if (last_stage) begin
                state   <= RUN;
                o_ready <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          RUN: begin
            loss_cnt <= lk ? '0 : loss_cnt + 1'b1;
          end
          default: begin
            state <= WAIT_LOCK;
            o_rst <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_seq_boolean.sv
// Scenario bench for rst_seq_boolean at default parameters; expected outputs are
// queued per edge when stimulus is applied and compared on the falling clock edge.
module tb_rst_seq_boolean;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sw_rst = 1'b0;
  logic [0:0] locked = 1'b0;
  logic [1:0] rst_o;
  logic       ready;
  logic [7:0] cnt;
  logic [1:0] state;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] rst;
    logic       rdy;
    logic [1:0] st;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  rst_seq_boolean dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_locked        (locked),
    .i_sw_rst        (sw_rst),
    .o_rst           (rst_o),
    .o_ready         (ready),
    .o_lock_loss_cnt (cnt),
    .o_state         (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(int c, logic [1:0] r, logic rd, logic [1:0] s, logic [7:0] n);
    sb.push_back('{c, r, rd, s, n});
  endfunction

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (state !== s) begin
      n_errors++;
      $display("FAIL %s: state=%0d after %0d cycles, required %0d", tag, state, n, s);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    locked = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rst_o !== 2'b11 || ready !== 1'b0 || state !== 2'd0 || cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset: rst=%b ready=%b state=%0d cnt=%0d, required rst=11 ready=0 state=0 cnt=0",
               rst_o, ready, state, cnt);
    end
  endtask

  task automatic test_cold_start();
    exp_t e;
    int base;
    rst_n = 1'b1;
    locked = 1'b1;
    base = cyc;
    expect_at(base + 1,  2'b11, 1'b0, 2'd0, 8'd0);
    expect_at(base + 2,  2'b11, 1'b0, 2'd0, 8'd0);
    expect_at(base + 3,  2'b11, 1'b0, 2'd1, 8'd0);
    expect_at(base + 18, 2'b11, 1'b0, 2'd1, 8'd0);
    expect_at(base + 19, 2'b10, 1'b0, 2'd2, 8'd0);
    expect_at(base + 26, 2'b10, 1'b0, 2'd2, 8'd0);
    expect_at(base + 27, 2'b00, 1'b1, 2'd3, 8'd0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (rst_o !== e.rst || ready !== e.rdy || state !== e.st || cnt !== e.cnt) begin
          n_errors++;
          $display("FAIL cold_start edge %0d: got rst=%b rdy=%b st=%0d cnt=%0d, required rst=%b rdy=%b st=%0d cnt=%0d",
                   e.cyc - base, rst_o, ready, state, cnt, e.rst, e.rdy, e.st, e.cnt);
        end
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int base;
    base = cyc;
    locked = 1'b0;
    expect_at(base + 3,  2'b00, 1'b1, 2'd3, 8'd0);
    expect_at(base + 5,  2'b00, 1'b1, 2'd3, 8'd0);
    expect_at(base + 6,  2'b00, 1'b1, 2'd3, 8'd0);
    expect_at(base + 8,  2'b00, 1'b1, 2'd3, 8'd0);
    expect_at(base + 15, 2'b00, 1'b1, 2'd3, 8'd0);
    expect_at(base + 16, 2'b11, 1'b0, 2'd0, 8'd1);
    expect_at(base + 20, 2'b11, 1'b0, 2'd0, 8'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (rst_o !== e.rst || ready !== e.rdy || state !== e.st || cnt !== e.cnt) begin
          n_errors++;
          $display("FAIL glitch edge %0d: got rst=%b rdy=%b st=%0d cnt=%0d, required rst=%b rdy=%b st=%0d cnt=%0d",
                   e.cyc - base, rst_o, ready, state, cnt, e.rst, e.rdy, e.st, e.cnt);
        end
      end
      if (k == 3)  locked = 1'b1;
      if (k == 10) locked = 1'b0;
    end
  endtask

  task automatic test_hold_abort();
    exp_t e;
    int base;
    base = cyc;
    locked = 1'b1;
    expect_at(base + 2,  2'b11, 1'b0, 2'd0, 8'd1);
    expect_at(base + 3,  2'b11, 1'b0, 2'd1, 8'd1);
    expect_at(base + 13, 2'b11, 1'b0, 2'd1, 8'd1);
    expect_at(base + 14, 2'b11, 1'b0, 2'd0, 8'd1);
    expect_at(base + 16, 2'b11, 1'b0, 2'd0, 8'd1);
    expect_at(base + 17, 2'b11, 1'b0, 2'd1, 8'd1);
    expect_at(base + 23, 2'b11, 1'b0, 2'd1, 8'd1);
    expect_at(base + 32, 2'b11, 1'b0, 2'd1, 8'd1);
    expect_at(base + 33, 2'b10, 1'b0, 2'd2, 8'd1);
    expect_at(base + 40, 2'b10, 1'b0, 2'd2, 8'd1);
    expect_at(base + 41, 2'b00, 1'b1, 2'd3, 8'd1);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (rst_o !== e.rst || ready !== e.rdy || state !== e.st || cnt !== e.cnt) begin
          n_errors++;
          $display("FAIL hold_abort edge %0d: got rst=%b rdy=%b st=%0d cnt=%0d, required rst=%b rdy=%b st=%0d cnt=%0d",
                   e.cyc - base, rst_o, ready, state, cnt, e.rst, e.rdy, e.st, e.cnt);
        end
      end
      if (k == 11) locked = 1'b0;
      if (k == 14) locked = 1'b1;
    end
  endtask

  task automatic test_sw_rst();
    exp_t e;
    int base;
    base = cyc;
    sw_rst = 1'b1;
    expect_at(base + 1,  2'b11, 1'b0, 2'd0, 8'd1);
    expect_at(base + 2,  2'b11, 1'b0, 2'd1, 8'd1);
    expect_at(base + 17, 2'b11, 1'b0, 2'd1, 8'd1);
    expect_at(base + 18, 2'b10, 1'b0, 2'd2, 8'd1);
    expect_at(base + 26, 2'b00, 1'b1, 2'd3, 8'd1);
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (rst_o !== e.rst || ready !== e.rdy || state !== e.st || cnt !== e.cnt) begin
          n_errors++;
          $display("FAIL sw_rst edge %0d: got rst=%b rdy=%b st=%0d cnt=%0d, required rst=%b rdy=%b st=%0d cnt=%0d",
                   e.cyc - base, rst_o, ready, state, cnt, e.rst, e.rdy, e.st, e.cnt);
        end
      end
      if (k == 1) sw_rst = 1'b0;
    end
  endtask

  task automatic test_sw_filter_coincide();
    exp_t e;
    int base;
    base = cyc;
    locked = 1'b0;
    expect_at(base + 5, 2'b00, 1'b1, 2'd3, 8'd1);
    expect_at(base + 6, 2'b11, 1'b0, 2'd0, 8'd2);
    expect_at(base + 8, 2'b11, 1'b0, 2'd0, 8'd2);
    expect_at(base + 9, 2'b11, 1'b0, 2'd1, 8'd2);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (rst_o !== e.rst || ready !== e.rdy || state !== e.st || cnt !== e.cnt) begin
          n_errors++;
          $display("FAIL coincide edge %0d: got rst=%b rdy=%b st=%0d cnt=%0d, required rst=%b rdy=%b st=%0d cnt=%0d",
                   e.cyc - base, rst_o, ready, state, cnt, e.rst, e.rdy, e.st, e.cnt);
        end
      end
      if (k == 5) sw_rst = 1'b1;
      if (k == 6) begin
        sw_rst = 1'b0;
        locked = 1'b1;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int base;
    wait_state(2'd2, 40, "async_reset_reach_release");
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rst_o !== 2'b11 || ready !== 1'b0 || state !== 2'd0 || cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL async_reset: got rst=%b rdy=%b st=%0d cnt=%0d, required rst=11 rdy=0 st=0 cnt=0",
               rst_o, ready, state, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    expect_at(base + 1, 2'b11, 1'b0, 2'd0, 8'd0);
    expect_at(base + 2, 2'b11, 1'b0, 2'd0, 8'd0);
    expect_at(base + 3, 2'b11, 1'b0, 2'd1, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (rst_o !== e.rst || ready !== e.rdy || state !== e.st || cnt !== e.cnt) begin
          n_errors++;
          $display("FAIL async_restart edge %0d: got rst=%b rdy=%b st=%0d cnt=%0d, required rst=%b rdy=%b st=%0d cnt=%0d",
                   e.cyc - base, rst_o, ready, state, cnt, e.rst, e.rdy, e.st, e.cnt);
        end
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int i = 1; i <= 257; i++) begin
      locked = 1'b1;
      wait_state(2'd2, 60, "saturation_reach_release");
      locked = 1'b0;
      expect_at(i, 2'b11, 1'b0, 2'd0, (i > 255) ? 8'd255 : 8'(i));
      wait_state(2'd0, 20, "saturation_reach_wait_lock");
      e = sb.pop_front();
      n_checks++;
      if (rst_o !== e.rst || ready !== e.rdy || state !== e.st || cnt !== e.cnt) begin
        n_errors++;
        $display("FAIL saturation loss %0d: got rst=%b rdy=%b st=%0d cnt=%0d, required rst=%b rdy=%b st=%0d cnt=%0d",
                 i, rst_o, ready, state, cnt, e.rst, e.rdy, e.st, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_glitch();
    test_hold_abort();
    test_sw_rst();
    test_sw_filter_coincide();
    test_async_reset();
    test_saturation();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
